we_task_seq: RTL and testbench
==============================

# we_task_seq

Parametrised multi-channel task sequencer for the electrochemistry front-end, next generation of the fixed two-engine task trigger. It replays a host-programmed step table: each step pulses triggers to a subset of NCH acquisition/stimulus engines (DAC, ADC, SPI, ...), then waits for a chosen subset of their done flags. The table runs N_LOOPS times. The block sits in the 512 kHz logic domain, between the host register interface and the engine controllers.

## Interface
- NCH, 2: number of engine channels (1..8)
- DEPTH, 16: step-table entries (power of 2, 2..64)
- LW, 16: loop-counter width
- clk  in  1  logic clock (512 kHz domain)
- rst  in  1  reset; synchronous, active-high
- cfg_wr  in  1  write step word at cfg_addr
- cfg_addr  in  $clog2(DEPTH)  table address
- cfg_data  in  2*NCH+1  step word: {last, wait_mask[NCH], trig_mask[NCH]}
- n_loops  in  LW  table repetitions; 0 treated as 1; sampled at start
- start  in  1  begin sequence (level or pulse; edge-insensitive, acted on in IDLE only)
- abort  in  1  terminate sequence
- done_in  in  NCH  per-engine done pulses/levels
- trig_out  out  NCH  per-engine trigger, one-cycle pulse
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at normal completion
- step_idx  out  $clog2(DEPTH)  current step
- loop_cnt  out  LW  completed loops
- cfg_err  out  1  sticky: cfg_wr attempted while busy

## Operation
- Table: DEPTH x (2*NCH+1) register array. Not reset. Writable only in IDLE; a write while busy is dropped and sets cfg_err.
- States: IDLE, FIRE, WAIT, NEXT, DONE.
- IDLE, start=1: latch n_loops (0 becomes 1), clear step_idx, loop_cnt, seen and cfg_err, then go to FIRE.
- FIRE, one cycle: trig_out = table[step_idx].trig_mask; clear seen, then OR in done_in. Next state is WAIT, or NEXT if wait_mask==0.
- WAIT: seen |= done_in. Exit to NEXT on the edge where (seen|done_in) & wait_mask == wait_mask. Bits outside wait_mask are ignored. There is no timeout; abort is the only escape.
- NEXT, one cycle: if last=1 or step_idx==DEPTH-1, the loop ends.
  - If loop_cnt+1 < n_loops_latched: loop_cnt++, step_idx=0, go to FIRE.
  - Otherwise: loop_cnt++, go to DONE.
  - If the loop has not ended: step_idx++, go to FIRE.
- DONE: done=1 for one cycle, then go to IDLE. step_idx and loop_cnt hold their final values until the next start.
- abort, in any state, has priority over all transitions: go to IDLE on the next edge. No done pulse; trig_out=0 from that cycle on.
- start while busy is ignored.
- Counter arithmetic is unsigned and non-saturating. loop_cnt cannot exceed n_loops, so it never wraps.

## Timing
- Reset values: trig_out=0, busy=0, done=0, step_idx=0, loop_cnt=0, cfg_err=0, state IDLE.
- start sampled at edge k: FIRE during cycle k+1, with trig_out and busy high.
- A step with wait_mask=0 takes 2 cycles (FIRE, NEXT).
- A step with a wait takes 2 + (cycles until the covering done) cycles. Minimum is 3 if done arrives during the first WAIT cycle. If done_in is already high during FIRE, the step still spends one WAIT cycle.
- done is asserted the cycle after NEXT of the final loop. busy falls the cycle after done.
- All outputs are registered, with no combinational path from inputs to outputs.
- Simultaneous abort and covering done_in: abort wins.
- Simultaneous cfg_wr and start in IDLE: the write completes and start proceeds. A write to step 0 takes effect in the first FIRE.

## Structure
- Shared package we_pkg holds:
  - state enum: IDLE, FIRE, WAIT, NEXT, DONE
  - step-word field offsets as localparams derived from NCH
  - function step_w(NCH) = 2*NCH+1
- One sub-module: we_step_ram, a synchronous-write, asynchronous-read table. The FSM plus counters form the top.

## Test plan
- NCH=2, table {step0: trig=01, wait=01; step1: trig=10, wait=10, last}, n_loops=1, done_in[0] 3 cycles after trig_out[0], same for done_in[1] -> trig_out 01 then 10, done pulses once, loop_cnt=1, step_idx=1.
- Same table, n_loops=3 -> trig pattern 01,10 repeated 3 times, exactly one done, loop_cnt=3.
- n_loops=0 -> behaves as 1; done after a single pass.
- step0 wait=11, done_in[1] at cycle +2, done_in[0] at cycle +6 -> exits WAIT only after cycle +6. Extra done_in bits outside the mask have no effect.
- abort asserted mid-WAIT -> busy=0 next cycle, no done, trig_out stays 0; a new start restarts from step 0.
- cfg_wr during busy -> table unchanged, cfg_err=1 until the next start. DEPTH=4 with no last bit -> ends after step 3.

Source files
------------

// File: rtl/we_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : we_pkg
//  Description : Shared types and step-word layout helpers for the task
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package we_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FIRE = 3'd1,
        WAIT = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int c_TRIG_LSB = 0;

    // Step word layout, LSB first: trig_mask[NCH], wait_mask[NCH], last.
    function automatic int step_w(input int nch);
        return 2 * nch + 1;
    endfunction

    function automatic int wait_lsb(input int nch);
        return c_TRIG_LSB + nch;
    endfunction

    function automatic int last_bit(input int nch);
        return 2 * nch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/we_step_ram.sv
`default_nettype none
// ============================================================================
//  Module      : we_step_ram
//  Description : Step table, synchronous write, asynchronous read, no reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module we_step_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 5,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/we_task_seq.sv
`default_nettype none
// ============================================================================
//  Module      : we_task_seq
//  Description : Multi-channel task sequencer replaying a host-programmed
//                trigger/wait step table for N loops.
//  Revision    : 1.0 - initial release
// ============================================================================
module we_task_seq
    import we_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 16,
    parameter int LW    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [2*NCH:0]           cfg_data,
    input  logic [LW-1:0]            n_loops,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NCH-1:0]           done_in,
    output logic [NCH-1:0]           trig_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic [LW-1:0]            loop_cnt,
    output logic                     cfg_err
);

    localparam int c_AW       = $clog2(DEPTH);
    localparam int c_SW       = step_w(NCH);
    localparam int c_WAIT_LSB = wait_lsb(NCH);
    localparam int c_LAST_BIT = last_bit(NCH);

    state_t          r_state, w_state_nx;
    logic [c_AW-1:0] r_step_idx, w_step_idx_nx;
    logic [LW-1:0]   r_loop_cnt, w_loop_cnt_nx;
    logic [LW-1:0]   r_n_loops, w_n_loops_nx;
    logic [NCH-1:0]  r_seen, w_seen_nx;
    logic            r_cfg_err, w_cfg_err_nx;

    logic            w_ram_we;
    logic [c_SW-1:0] w_step;
    logic [NCH-1:0]  w_trig_mask;
    logic [NCH-1:0]  w_wait_mask;
    logic            w_last;
    logic            w_loop_end;
    logic            w_covered;
    logic [LW-1:0]   w_loop_inc;

    assign w_ram_we = cfg_wr && (r_state == IDLE);

    we_step_ram #(
        .DEPTH (DEPTH),
        .W     (c_SW)
    ) u_step_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (cfg_addr),
        .i_wr_data (cfg_data),
        .i_rd_addr (r_step_idx),
        .o_rd_data (w_step)
    );

    assign w_trig_mask = w_step[c_TRIG_LSB +: NCH];
    assign w_wait_mask = w_step[c_WAIT_LSB +: NCH];
    assign w_last      = w_step[c_LAST_BIT];
    assign w_loop_end  = w_last || (r_step_idx == c_AW'(DEPTH - 1));
    // done_in is folded in combinationally so a done arriving on the exit edge counts.
    assign w_covered   = (((r_seen | done_in) & w_wait_mask) == w_wait_mask);
    assign w_loop_inc  = r_loop_cnt + LW'(1);

    always_comb begin
        w_state_nx    = r_state;
        w_step_idx_nx = r_step_idx;
        w_loop_cnt_nx = r_loop_cnt;
        w_n_loops_nx  = r_n_loops;
        w_seen_nx     = r_seen;
        w_cfg_err_nx  = r_cfg_err;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_n_loops_nx  = (n_loops == '0) ? LW'(1) : n_loops;
                    w_step_idx_nx = '0;
                    w_loop_cnt_nx = '0;
                    w_seen_nx     = '0;
                    w_cfg_err_nx  = 1'b0;
                    w_state_nx    = FIRE;
                end
            end
            FIRE: begin
                w_seen_nx  = done_in;
                w_state_nx = (w_wait_mask == '0) ? NEXT : WAIT;
            end
            WAIT: begin
                w_seen_nx = r_seen | done_in;
                if (w_covered) begin
                    w_state_nx = NEXT;
                end
            end
            NEXT: begin
                if (w_loop_end) begin
                    w_loop_cnt_nx = w_loop_inc;
                    if (w_loop_inc < r_n_loops) begin
                        w_step_idx_nx = '0;
                        w_state_nx    = FIRE;
                    end else begin
                        w_state_nx = DONE;
                    end
                end else begin
                    w_step_idx_nx = r_step_idx + c_AW'(1);
                    w_state_nx    = FIRE;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Abort freezes the counters so the host can see where the sequence stopped.
        if (abort) begin
            w_state_nx    = IDLE;
            w_step_idx_nx = r_step_idx;
            w_loop_cnt_nx = r_loop_cnt;
            w_n_loops_nx  = r_n_loops;
            w_seen_nx     = r_seen;
            w_cfg_err_nx  = r_cfg_err;
        end

        if (cfg_wr && (r_state != IDLE)) begin
            w_cfg_err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_step_idx <= '0;
            r_loop_cnt <= '0;
            r_n_loops  <= '0;
            r_seen     <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_step_idx <= w_step_idx_nx;
            r_loop_cnt <= w_loop_cnt_nx;
            r_n_loops  <= w_n_loops_nx;
            r_seen     <= w_seen_nx;
            r_cfg_err  <= w_cfg_err_nx;
        end
    end

    assign trig_out = (r_state == FIRE) ? w_trig_mask : '0;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign step_idx = r_step_idx;
    assign loop_cnt = r_loop_cnt;
    assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_we_task_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_we_task_seq
//  Description : Scoreboard bench for we_task_seq with an auto-responding
//                engine model (NCH=2, DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_we_task_seq;

    localparam int c_NCH   = 2;
    localparam int c_DEPTH = 4;
    localparam int c_LW    = 16;
    localparam int c_AW    = $clog2(c_DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [c_AW-1:0]   cfg_addr = '0;
    logic [2*c_NCH:0]  cfg_data = '0;
    logic [c_LW-1:0]   n_loops = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [c_NCH-1:0]  done_in = '0;
    logic [c_NCH-1:0]  trig_out;
    logic              busy;
    logic              done;
    logic [c_AW-1:0]   step_idx;
    logic [c_LW-1:0]   loop_cnt;
    logic              cfg_err;

    we_task_seq #(
        .NCH   (c_NCH),
        .DEPTH (c_DEPTH),
        .LW    (c_LW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .n_loops  (n_loops),
        .start    (start),
        .abort    (abort),
        .done_in  (done_in),
        .trig_out (trig_out),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx),
        .loop_cnt (loop_cnt),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_trig_cyc = 0;
    int done_cnt = 0;

    logic [c_NCH-1:0] exp_trig_q [$];
    int               exp_gap_q [$];
    int               exp_loop_q [$];
    int               exp_step_q [$];

    int dly  [c_NCH];
    int rcnt [c_NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] sw(input logic last, input logic [1:0] wm, input logic [1:0] tm);
        return {last, wm, tm};
    endfunction

    // Scoreboard: trigger words/gaps and done-time counters.
    always @(negedge clk) begin
        cyc++;
        if (trig_out != '0) begin
            if (exp_trig_q.size() == 0) begin
                chk("trig_unexpected", 32'(trig_out), 32'd0);
            end else begin
                logic [c_NCH-1:0] et;
                int               eg;
                et = exp_trig_q.pop_front();
                eg = exp_gap_q.pop_front();
                chk("trig_word", 32'(trig_out), 32'(et));
                if (eg >= 0) chk("trig_gap", 32'(cyc - last_trig_cyc), 32'(eg));
            end
            last_trig_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            if (exp_loop_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                chk("done_loop_cnt", 32'(loop_cnt), 32'(exp_loop_q.pop_front()));
                chk("done_step_idx", 32'(step_idx), 32'(exp_step_q.pop_front()));
            end
        end
    end

    // Engine model: each triggered channel answers dly[c] cycles later with a 1-cycle done.
    always @(negedge clk) begin
        for (int c = 0; c < c_NCH; c++) begin
            done_in[c] = 1'b0;
            if (rcnt[c] > 0) begin
                rcnt[c] = rcnt[c] - 1;
                if (rcnt[c] == 0) done_in[c] = 1'b1;
            end
            if (trig_out[c]) rcnt[c] = dly[c];
        end
    end

    task automatic wr(input logic [c_AW-1:0] a, input logic [4:0] d);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic push_trig(input logic [1:0] t, input int gap);
        exp_trig_q.push_back(t);
        exp_gap_q.push_back(gap);
    endtask

    task automatic push_done(input int lc, input int si);
        exp_loop_q.push_back(lc);
        exp_step_q.push_back(si);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic run(input string tag, input logic [c_LW-1:0] nl, input int exp_dones);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        n_loops = nl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(tag);
        @(negedge clk);
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'(exp_dones));
        chk({tag, "_sb_empty"}, 32'(exp_trig_q.size() + exp_loop_q.size()), 32'd0);
    endtask

    initial begin
        dly[0] = 3; dly[1] = 3;
        rcnt[0] = 0; rcnt[1] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_trig_out", 32'(trig_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_step_idx", 32'(step_idx), 32'd0);
        chk("rst_loop_cnt", 32'(loop_cnt), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);

        // Two-step table, single pass.
        wr(2'd0, sw(1'b0, 2'b01, 2'b01));
        wr(2'd1, sw(1'b1, 2'b10, 2'b10));
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        push_done(1, 1);
        run("one_loop", 16'd1, 1);

        // Three passes: gap across the loop boundary equals an in-loop step.
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        for (int i = 0; i < 2; i++) begin
            push_trig(2'b01, 5); push_trig(2'b10, 5);
        end
        push_done(3, 1);
        run("three_loops", 16'd3, 1);

        // n_loops=0 behaves as one pass.
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        push_done(1, 1);
        run("zero_loops", 16'd0, 1);

        // Two-channel wait: exit only after the later done.
        wr(2'd0, sw(1'b1, 2'b11, 2'b11));
        dly[0] = 6; dly[1] = 2;
        push_trig(2'b11, -1); push_trig(2'b11, 8);
        push_done(2, 0);
        run("wait_both", 16'd2, 1);

        // Done on a channel outside the mask has no effect.
        wr(2'd0, sw(1'b1, 2'b01, 2'b11));
        dly[0] = 4; dly[1] = 1;
        push_trig(2'b11, -1); push_trig(2'b11, 6);
        push_done(2, 0);
        run("mask_ignore", 16'd2, 1);

        // Abort mid-WAIT.
        wr(2'd0, sw(1'b0, 2'b01, 2'b01));
        dly[0] = 20; dly[1] = 3;
        begin
            int d0;
            int trig_seen;
            d0 = done_cnt;
            trig_seen = 0;
            push_trig(2'b01, -1);
            @(negedge clk);
            n_loops = 16'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_trig", 32'(trig_out), 32'd0);
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (trig_out != '0 || busy) trig_seen++;
            end
            chk("abort_quiet", 32'(trig_seen), 32'd0);
            chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end
        dly[0] = 3;
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        push_done(1, 1);
        run("restart", 16'd1, 1);

        // Write while busy is dropped and flags cfg_err.
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        push_done(1, 1);
        @(negedge clk);
        n_loops = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_data = sw(1'b1, 2'b11, 2'b11);
        @(negedge clk);
        cfg_wr = 1'b0;
        chk("cfg_err_set", 32'(cfg_err), 32'd1);
        wait_idle("busy_wr_run");
        @(negedge clk);
        chk("cfg_err_sticky", 32'(cfg_err), 32'd1);
        push_trig(2'b01, -1); push_trig(2'b10, 5);
        push_done(1, 1);
        run("table_kept", 16'd1, 1);
        chk("cfg_err_cleared", 32'(cfg_err), 32'd0);

        // No last bit: table ends after step DEPTH-1; step 0 written alongside start.
        wr(2'd1, sw(1'b0, 2'b00, 2'b10));
        wr(2'd2, sw(1'b0, 2'b00, 2'b11));
        wr(2'd3, sw(1'b0, 2'b00, 2'b01));
        push_trig(2'b10, -1); push_trig(2'b10, 2); push_trig(2'b11, 2); push_trig(2'b01, 2);
        push_done(1, 3);
        begin
            int d0;
            d0 = done_cnt;
            @(negedge clk);
            cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_data = sw(1'b0, 2'b00, 2'b10);
            n_loops = 16'd1; start = 1'b1;
            @(negedge clk);
            cfg_wr = 1'b0; start = 1'b0;
            chk("wr_start_no_err", 32'(cfg_err), 32'd0);
            wait_idle("full_depth");
            @(negedge clk);
            chk("full_depth_done_count", 32'(done_cnt - d0), 32'd1);
            chk("full_depth_sb_empty", 32'(exp_trig_q.size() + exp_loop_q.size()), 32'd0);
            chk("hold_step_idx", 32'(step_idx), 32'd3);
            chk("hold_loop_cnt", 32'(loop_cnt), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
